// File: rtl/ids_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared IDS pipeline.
// Ports: clk, reset (async, active-low); in_data/in_ctrl/in_empty/in_rd_en
// (per-queue fallthrough heads and pops); out_data/out_ctrl/out_wr/out_rdy
// (IDS side); arb_en/arb_idle (drain handshake); cur_q (granted queue).
// Optional IDS_INPUT_ARBITER_PKT_CNT_EN adds cnt_clr and per-queue pkt_cnt.
module ids_input_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8,
   parameter int NUM_QUEUES = 4,
   parameter int QSEL_WIDTH = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_QUEUES-1:0]            in_empty,
   output logic [NUM_QUEUES-1:0]            in_rd_en,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   input  logic                             arb_en,
   output logic                             arb_idle,
`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
   input  logic                             cnt_clr,
   output logic [NUM_QUEUES*32-1:0]         pkt_cnt,
`endif
   output logic [QSEL_WIDTH-1:0]            cur_q
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]            state;
   logic                  body_seen;
   logic [QSEL_WIDTH-1:0] last_q;
   logic [QSEL_WIDTH-1:0] next_q;
   logic                  found;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [CTRL_WIDTH-1:0] sel_ctrl;
   logic                  sel_empty;
   logic                  xfer;
   logic                  eop;
   logic                  grant;

   // Rotating search starting just after the last served queue.
   always_comb begin
      found  = 1'b0;
      next_q = '0;
      for (int k = 1; k <= NUM_QUEUES; k++) begin
         for (int j = 0; j < NUM_QUEUES; j++) begin
            if (!found && !in_empty[j] &&
                j == (int'(last_q) + k) % NUM_QUEUES) begin
               found  = 1'b1;
               next_q = QSEL_WIDTH'(j);
            end
         end
      end
   end

   always_comb begin
      sel_data  = '0;
      sel_ctrl  = '0;
      sel_empty = 1'b1;
      for (int j = 0; j < NUM_QUEUES; j++) begin
         if (cur_q == QSEL_WIDTH'(j)) begin
            sel_data  = in_data[j*DATA_WIDTH +: DATA_WIDTH];
            sel_ctrl  = in_ctrl[j*CTRL_WIDTH +: CTRL_WIDTH];
            sel_empty = in_empty[j];
         end
      end
   end

   assign xfer  = (state == XFER) && !sel_empty && out_rdy;
   // Trailing ctrl word only counts as EOP once a body word has passed.
   assign eop   = xfer && (sel_ctrl != '0) && body_seen;
   assign grant = (state == IDLE) && arb_en && found;

   always_comb begin
      in_rd_en = '0;
      for (int j = 0; j < NUM_QUEUES; j++) begin
         in_rd_en[j] = xfer && (cur_q == QSEL_WIDTH'(j));
      end
   end

   assign out_data = sel_data;
   assign out_ctrl = sel_ctrl;
   assign out_wr   = xfer;
   assign arb_idle = (state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         body_seen <= 1'b0;
         last_q    <= QSEL_WIDTH'(NUM_QUEUES - 1);
         cur_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant) begin
                  state     <= XFER;
                  cur_q     <= next_q;
                  body_seen <= 1'b0;
               end
            end
            XFER: begin
               if (eop) begin
                  state  <= IDLE;
                  last_q <= cur_q;
               end else if (xfer && sel_ctrl == '0) begin
                  body_seen <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pkt_cnt <= '0;
      end else if (cnt_clr) begin
         pkt_cnt <= '0;
      end else begin
         for (int j = 0; j < NUM_QUEUES; j++) begin
            if (eop && cur_q == QSEL_WIDTH'(j)) begin
               pkt_cnt[j*32 +: 32] <= pkt_cnt[j*32 +: 32] + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_ids_input_arbiter.sv
// Directed bench for ids_input_arbiter: models four fallthrough queues
// and checks grant order, framing, stalls, drain and reset behaviour.
module tb_ids_input_arbiter;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int NQ = 4;
   localparam int QW = 3;

   logic            clk;
   logic            reset;
   logic [NQ*DW-1:0] in_data;
   logic [NQ*CW-1:0] in_ctrl;
   logic [NQ-1:0]    in_empty;
   logic [NQ-1:0]    in_rd_en;
   logic [DW-1:0]    out_data;
   logic [CW-1:0]    out_ctrl;
   logic             out_wr;
   logic             out_rdy;
   logic             arb_en;
   logic             arb_idle;
   logic [QW-1:0]    cur_q;
`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
   logic             cnt_clr;
   logic [NQ*32-1:0] pkt_cnt;
`endif

   ids_input_arbiter #(
      .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .QSEL_WIDTH(QW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .in_empty(in_empty), .in_rd_en(in_rd_en),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .out_wr(out_wr), .out_rdy(out_rdy),
      .arb_en(arb_en), .arb_idle(arb_idle),
`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
      .cnt_clr(cnt_clr), .pkt_cnt(pkt_cnt),
`endif
      .cur_q(cur_q)
   );

   always #5 clk = ~clk;

   logic [63:0] qd [NQ][64];
   logic [7:0]  qc [NQ][64];
   int          wr_p [NQ];
   int          rd_p [NQ];
   logic [NQ-1:0] hold;
   int checks;
   int errors;

   function automatic logic [63:0] expd(int q, int tag, int w);
      return (64'(q) << 56) | (64'(tag) << 8) | 64'(w);
   endfunction

   function automatic logic [7:0] expc(int w);
      if (w < 2) return 8'hFF;
      if (w == 5) return 8'h80;
      return 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NQ; i++) begin
         in_data[i*DW +: DW] = qd[i][rd_p[i]];
         in_ctrl[i*CW +: CW] = qc[i][rd_p[i]];
         in_empty[i] = hold[i] || (rd_p[i] == wr_p[i]);
      end
      #1;
   endtask

   task automatic cyc();
      logic [NQ-1:0] rd;
      rd = in_rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < NQ; i++) if (rd[i]) rd_p[i]++;
      drive();
   endtask

   task automatic push_pkt(input int q, input int tag);
      for (int w = 0; w < 6; w++) begin
         qd[q][wr_p[q]] = expd(q, tag, w);
         qc[q][wr_p[q]] = expc(w);
         wr_p[q]++;
      end
      drive();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_idle_wr"}, out_wr, 0);
      chk({tag, "_idle"}, arb_idle, 1);
      cyc();
   endtask

   task automatic chk_words(input string tag, input int q, input int t,
                            input int lo, input int hi);
      for (int w = lo; w <= hi; w++) begin
         chk({tag, "_wr"}, out_wr, 1);
         chk({tag, "_q"}, cur_q, 64'(q));
         chk({tag, "_rd"}, in_rd_en, 64'(1) << q);
         chk({tag, "_data"}, out_data, expd(q, t, w));
         chk({tag, "_ctrl"}, out_ctrl, expc(w));
         cyc();
      end
   endtask

   task automatic expect_pkt(input string tag, input int q, input int t);
      chk_idle(tag);
      chk_words(tag, q, t, 0, 5);
   endtask

   initial begin
      clk = 0;
      reset = 0;
      out_rdy = 1;
      arb_en = 0;
      hold = '0;
      checks = 0;
      errors = 0;
`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
      cnt_clr = 0;
`endif
      for (int i = 0; i < NQ; i++) begin
         wr_p[i] = 0;
         rd_p[i] = 0;
         for (int j = 0; j < 64; j++) begin
            qd[i][j] = '0;
            qc[i][j] = '0;
         end
      end
      drive();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_idle", arb_idle, 1);
      chk("rst_wr", out_wr, 0);
      chk("rst_rd", in_rd_en, 0);
      chk("rst_q", cur_q, 0);
      reset = 1;
      cyc();

      // 1: one packet per queue, strict order 0..3
      for (int q = 0; q < NQ; q++) push_pkt(q, 16 + q);
      cyc();
      chk("t1_noen_idle", arb_idle, 1);
      chk("t1_noen_rd", in_rd_en, 0);
      arb_en = 1;
      #1;
      for (int q = 0; q < NQ; q++) expect_pkt("t1", q, 16 + q);
      chk("t1_end_idle", arb_idle, 1);

      // 2: single queue back-to-back
      for (int p = 0; p < 3; p++) push_pkt(2, 32 + p);
      for (int p = 0; p < 3; p++) expect_pkt("t2", 2, 32 + p);

      // 3: mid-body starvation of queue 1 while queue 3 waits
      push_pkt(1, 48);
      chk_idle("t3");
      chk_words("t3a", 1, 48, 0, 2);
      hold[1] = 1;
      push_pkt(3, 49);
      for (int i = 0; i < 4; i++) begin
         chk("t3_stall_wr", out_wr, 0);
         chk("t3_stall_rd", in_rd_en, 0);
         chk("t3_stall_q", cur_q, 1);
         cyc();
      end
      hold[1] = 0;
      drive();
      chk_words("t3b", 1, 48, 3, 5);
      expect_pkt("t3c", 3, 49);

      // 4: drain via arb_en on the second word
      push_pkt(0, 64);
      push_pkt(1, 65);
      chk_idle("t4");
      chk_words("t4a", 0, 64, 0, 0);
      arb_en = 0;
      #1;
      chk_words("t4b", 0, 64, 1, 5);
      for (int i = 0; i < 3; i++) begin
         chk("t4_hold_idle", arb_idle, 1);
         chk("t4_hold_wr", out_wr, 0);
         cyc();
      end
      arb_en = 1;
      #1;
      expect_pkt("t4c", 1, 65);

      // 5: out_rdy toggling
      push_pkt(2, 80);
      chk_idle("t5");
      for (int w = 0; w < 6; w++) begin
         out_rdy = 0;
         #1;
         chk("t5_off_wr", out_wr, 0);
         chk("t5_off_rd", in_rd_en, 0);
         chk("t5_off_data", out_data, expd(2, 80, w));
         cyc();
         out_rdy = 1;
         #1;
         chk_words("t5_on", 2, 80, w, w);
      end

`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
      chk("cnt_q0", pkt_cnt[0*32 +: 32], 2);
      chk("cnt_q1", pkt_cnt[1*32 +: 32], 3);
      chk("cnt_q2", pkt_cnt[2*32 +: 32], 5);
      chk("cnt_q3", pkt_cnt[3*32 +: 32], 2);
`endif

      // 6: reset mid-packet
      push_pkt(1, 96);
      chk_idle("t6");
      chk_words("t6a", 1, 96, 0, 2);
      push_pkt(0, 97);
      reset = 0;
      #1;
      chk("t6_rst_wr", out_wr, 0);
      chk("t6_rst_idle", arb_idle, 1);
      chk("t6_rst_rd", in_rd_en, 0);
      chk("t6_rst_q", cur_q, 0);
`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
      chk("t6_rst_cnt", pkt_cnt, 0);
`endif
      cyc();
      reset = 1;
      #1;
      expect_pkt("t6b", 0, 97);
      chk_idle("t6c");
      chk_words("t6c", 1, 96, 3, 5);
      chk("t6_end_idle", arb_idle, 1);

`ifdef IDS_INPUT_ARBITER_PKT_CNT_EN
      chk("cnt6_q0", pkt_cnt[0*32 +: 32], 1);
      chk("cnt6_q1", pkt_cnt[1*32 +: 32], 1);
      cnt_clr = 1;
      cyc();
      cnt_clr = 0;
      #1;
      chk("cnt_clr", pkt_cnt, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ids_input_arbiter.md
Name: ids_input_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single IDS pipeline (input FIFO, pattern matcher, drop FIFO) among NUM_QUEUES upstream packet queues.
- Sits directly in front of the IDS module in the user data path and owns grant sequencing.
- Holds a grant for a whole packet so the matcher never sees interleaved words.
- Exposes a drain/idle handshake so control software can safely reload the pattern registers between packets.

Parameters:
- DATA_WIDTH, 64, datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8, control-bus width.
- NUM_QUEUES, 4, number of requesting queues (2..8).
- QSEL_WIDTH, 3, width of queue index; must satisfy 2^QSEL_WIDTH >= NUM_QUEUES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  NUM_QUEUES*DATA_WIDTH  head word of each fallthrough queue; queue i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  head ctrl of each queue, same packing.
- in_empty  in  NUM_QUEUES  queue i has no word available.
- in_rd_en  out  NUM_QUEUES  pops head of queue i.
- out_data  out  DATA_WIDTH  word to the IDS.
- out_ctrl  out  CTRL_WIDTH  ctrl to the IDS.
- out_wr  out  1  word valid/written this cycle.
- out_rdy  in  1  IDS can accept a word.
- arb_en  in  1  1 = grant new packets; 0 = finish the current packet, then hold.
- arb_idle  out  1  no packet in flight and no grant held.
- cur_q  out  QSEL_WIDTH  currently or last granted queue.

Behaviour:
- Reset values (asynchronous assert, synchronous release on clk):
  - state=IDLE, body_seen=0, last_q=NUM_QUEUES-1, cur_q=0.
  - in_rd_en=0, out_wr=0, arb_idle=1.
- States:
  - IDLE: no grant. Each cycle with arb_en=1 and any !in_empty:
    - Search queues last_q+1, last_q+2, ... (mod NUM_QUEUES) for the first non-empty queue.
    - Register it into cur_q; go to XFER; clear body_seen.
    - Costs exactly one bubble cycle; no word moves in IDLE.
  - XFER: data path is combinational (zero latency).
    - out_data/out_ctrl = head of queue cur_q.
    - out_wr = in_rd_en[cur_q] = !in_empty[cur_q] && out_rdy. All other in_rd_en bits are 0.
- Packet framing: header words have ctrl!=0, body words have ctrl==0, last word has ctrl!=0.
  - On any transferred word with ctrl==0: set body_seen.
  - On a transferred word with ctrl!=0 while body_seen=1: end of packet. Next cycle: last_q<=cur_q, state=IDLE.
- Queue cur_q goes empty mid-packet: out_wr=0; stall in XFER holding the grant, with no timeout.
- out_rdy low: no pop, no out_wr; grant held.
- arb_en falling mid-packet: the current packet completes; after EOP, stay in IDLE until arb_en=1.
- arb_idle = (state==IDLE).
  - Combinational, so it is 1 in the cycle after EOP even if another queue is pending.
  - Software sequence: deassert arb_en, wait for arb_idle, reconfigure, reassert arb_en.
- Header-less packet (first word ctrl==0): accepted; body_seen sets immediately. No error flagging.
- Single-queue traffic: the same queue is re-granted after a one-cycle bubble per packet.
- Reset mid-packet: the grant is dropped immediately. The downstream truncated packet is handled by the IDS reset path.
- out_data/out_ctrl in IDLE: driven from queue cur_q. Don't-care, since out_wr=0.

Optional Feature:
- Macro: IDS_INPUT_ARBITER_PKT_CNT_EN.
- Defined:
  - Adds port pkt_cnt out NUM_QUEUES*32: per-queue count of packets granted.
  - Each counter increments by 1 on the EOP word of its queue and wraps at 2^32-1 -> 0.
  - Counters clear on reset and on input cnt_clr (in, 1, synchronous). cnt_clr wins over a simultaneous increment.
- Undefined: neither port exists; no counter logic.

Test Plan:
1. Queues 0..3 each hold one packet (2 hdr ctrl=0xFF, 3 body ctrl=0, last ctrl=0x80), out_rdy=1 -> grants in order 0,1,2,3; each packet is 6 contiguous out_wr cycles with 1 bubble between; no interleaving.
2. Queue 2 only, 3 back-to-back packets -> cur_q=2 each time; packets separated by exactly 1 idle cycle.
3. Queue 1 goes empty for 4 cycles mid-body while queue 3 is non-empty -> out_wr=0 for 4 cycles; grant stays on 1; queue 3 is served only after the queue 1 EOP.
4. arb_en deasserted on the 2nd word of a queue 0 packet -> remaining words delivered; arb_idle=1 the cycle after EOP and remains 1 with queues pending; reassert -> next grant is queue 1.
5. out_rdy toggled 1,0,1,0 during a packet -> in_rd_en and out_wr are high only in out_rdy=1 cycles; no words lost or duplicated.
6. reset pulsed low mid-packet -> out_wr=0 and arb_idle=1 immediately; with IDS_INPUT_ARBITER_PKT_CNT_EN defined, all pkt_cnt=0; after release, a grant from queue 0 occurs first.
